// File: rtl/des_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : des_round_engine
// Description : Iterative DES Feistel core. Runs the 16 DES rounds, one per
//               clock, on a block that has already been through the initial
//               permutation, and emits the swapped preoutput R16||L16.
//               Holds the key-schedule state (C/D rotation plus PC-2). The
//               f-function (E, S-boxes, P) lives in an external
//               combinational des_f block reached through the f_* ports.
// Ports       :
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   i_in_valid    block/key/mode valid (taken only while idle)
//   o_in_ready    engine idle and able to accept
//   i_block_in    [0:63] IP-permuted block, L0=[0:31], R0=[32:63]
//   i_key_cd      [0:55] PC-1-permuted key, C0=[0:27], D0=[28:55]
//   i_decrypt     0=encrypt, 1=decrypt, sampled on accept
//   o_f_r         current R to des_f
//   o_f_k         current round subkey to des_f
//   i_f_out       des_f(o_f_r, o_f_k), same cycle
//   o_out_valid   preoutput valid
//   i_out_ready   downstream accepts preoutput
//   o_preoutput   [0:63] = R16||L16
//   Bit 0 is the MSB on every bus (DES bit 1 -> index 0).
// Revision    : 1.0 - initial release
// ============================================================================
module des_round_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [0:63] i_block_in,
  input  logic [0:55] i_key_cd,
  input  logic        i_decrypt,
  output logic [0:31] o_f_r,
  output logic [0:47] o_f_k,
  input  logic [0:31] i_f_out,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [0:63] o_preoutput
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // PC-2 selection table, 1-based positions into C||D.
  localparam logic [5:0] c_PC2 [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_rnd;
  logic        r_dec;
  logic [0:31] r_l;
  logic [0:31] r_r;
  logic [0:27] r_c;
  logic [0:27] r_d;
  logic [0:63] r_preout;

  logic [1:0]  w_amt;
  logic [0:27] w_c_nxt;
  logic [0:27] w_d_nxt;
  logic [0:31] w_r_nxt;

  // Per-round rotation amount. Decryption walks the encrypt schedule
  // backwards: C0/D0 already equal C16/D16 (total rotation is 28), so the
  // first decrypt round uses them unrotated and later rounds rotate right.
  function automatic logic [1:0] f_shift(input logic [3:0] rnd, input logic dec);
    logic [1:0] amt;
    if (rnd == 4'd0 || rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15)
      amt = 2'd1;
    else
      amt = 2'd2;
    if (dec && rnd == 4'd0)
      amt = 2'd0;
    return amt;
  endfunction

  // 28-bit rotate; "left" moves bits toward index 0 (the MSB).
  function automatic logic [0:27] f_rot28(input logic [0:27] x, input logic [1:0] amt,
                                          input logic right);
    logic [0:27] y;
    case (amt)
      2'd1:    y = right ? {x[27], x[0:26]} : {x[1:27], x[0]};
      2'd2:    y = right ? {x[26:27], x[0:25]} : {x[2:27], x[0:1]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [0:47] f_pc2(input logic [0:55] cd);
    logic [0:47] k;
    k = '0;
    for (int i = 0; i < 48; i++)
      k[i] = cd[int'(c_PC2[i]) - 1];
    return k;
  endfunction

  // Key schedule: outside RUN the rotation is zero so f_k shows PC2(C,D).
  always_comb begin
    w_amt   = (r_state == ST_RUN) ? f_shift(r_rnd, r_dec) : 2'd0;
    w_c_nxt = f_rot28(r_c, w_amt, r_dec);
    w_d_nxt = f_rot28(r_d, w_amt, r_dec);
    w_r_nxt = r_l ^ i_f_out;
  end

  assign o_f_k       = f_pc2({w_c_nxt, w_d_nxt});
  assign o_f_r       = r_r;
  assign o_preoutput = r_preout;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid)
          w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (r_rnd == 4'd15)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, one Feistel round per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd    <= 4'd0;
      r_dec    <= 1'b0;
      r_l      <= '0;
      r_r      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_preout <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_l   <= i_block_in[0:31];
            r_r   <= i_block_in[32:63];
            r_c   <= i_key_cd[0:27];
            r_d   <= i_key_cd[28:55];
            r_dec <= i_decrypt;
            r_rnd <= 4'd0;
          end
        end
        ST_RUN: begin
          r_l   <= r_r;
          r_r   <= w_r_nxt;
          r_c   <= w_c_nxt;
          r_d   <= w_d_nxt;
          r_rnd <= r_rnd + 4'd1;
          // Final swap: preoutput is R16||L16.
          if (r_rnd == 4'd15)
            r_preout <= {w_r_nxt, r_r};
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_des_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_round_engine
// Description : Self-checking bench for des_round_engine. Supplies a
//               behavioural des_f, drives directed vectors and checks the
//               preoutput through a scoreboard queue and an output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_round_engine;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:63] block_in;
  logic [0:55] key_cd;
  logic        decrypt;
  logic [0:31] f_r;
  logic [0:47] f_k;
  logic [0:31] f_out;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] preoutput;

  des_round_engine u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_block_in  (block_in),
    .i_key_cd    (key_cd),
    .i_decrypt   (decrypt),
    .o_f_r       (f_r),
    .o_f_k       (f_k),
    .i_f_out     (f_out),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_preoutput (preoutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [0:63] c_PT  = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [0:63] c_CT  = 64'h0A4CD995_43423234;
  localparam logic [0:55] c_KEY = 56'hF0CCAAF_556678F;
  localparam logic [0:47] c_K1  = 48'h1B02EFFC7072;

  // ---------------- behavioural des_f (E, S-boxes, P) ----------------
  localparam int E_T [0:47] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [0:31] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int S_T [0:511] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [0:31] des_f(input logic [0:31] r, input logic [0:47] k);
    logic [0:47] x;
    logic [0:31] s;
    logic [0:31] o;
    logic [0:5]  b;
    logic [3:0]  nib;
    int          row;
    int          col;
    x = '0;
    s = '0;
    o = '0;
    for (int i = 0; i < 48; i++) x[i] = r[E_T[i] - 1];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = x[6*j +: 6];
      row = {30'd0, b[0], b[5]};
      col = {28'd0, b[1:4]};
      nib = 4'(S_T[j*64 + row*16 + col]);
      s[4*j +: 4] = nib;
    end
    for (int i = 0; i < 32; i++) o[i] = s[P_T[i] - 1];
    return o;
  endfunction

  always_comb f_out = des_f(f_r, f_k);

  // ---------------- scoreboard and checking ----------------
  int          n_pass = 0;
  int          n_chk  = 0;
  logic [63:0] sb_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: every accepted preoutput is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_has_entry", {127'd0, sb_q.size() != 0}, 128'd1);
      if (sb_q.size() != 0) check("preoutput", preoutput, sb_q.pop_front());
    end
  end

  task automatic issue(input logic [0:63] blk, input logic dec, input bit push,
                       input logic [0:63] exp);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_issue", {127'd0, in_ready}, 128'd1);
    block_in = blk;
    key_cd   = c_KEY;
    decrypt  = dec;
    in_valid = 1'b1;
    if (push) sb_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid_within_bound", {127'd0, out_valid}, 128'd1);
    @(posedge clk); #1;
    check("idle_after_handshake", {126'd0, in_ready, out_valid}, 128'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    block_in = '0; key_cd = '0; decrypt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {f_r, in_ready, out_valid, preoutput}, {32'd0, 1'b1, 1'b0, 64'd0});
    rst = 1'b0;
    @(posedge clk); #1;

    // Encrypt: first-round subkey, latency, back-pressure hold.
    issue(c_PT, 1'b0, 1'b1, c_CT);
    check("first_round_fk", f_k, c_K1);
    check("first_round_fr", f_r, c_PT[32:63]);
    check("busy_in_ready", {127'd0, in_ready}, 128'd0);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("latency", cnt, 16);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      block_in = 64'h0123456789ABCDEF;
      @(posedge clk); #1;
      check("bp_hold", {out_valid, in_ready, preoutput}, {1'b1, 1'b0, c_CT});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_pulse", {126'd0, in_ready, out_valid}, 128'b10);

    // Decrypt vector.
    issue(c_CT, 1'b1, 1'b1, c_PT);
    drain();

    // Asynchronous reset with no clock edge clears held preoutput.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_reset_idle", {in_ready, out_valid, preoutput}, {1'b1, 1'b0, 64'd0});
    @(posedge clk); #1;
    rst = 1'b0;

    // Mid-run reset at rnd=7, then a clean encrypt.
    out_ready = 1'b0;
    issue(c_PT, 1'b0, 1'b0, 64'd0);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset", {in_ready, out_valid, f_r}, {1'b1, 1'b0, 32'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    issue(c_PT, 1'b0, 1'b1, c_CT);
    drain();

    // Inputs disturbed during RUN must not affect the result.
    out_ready = 1'b0;
    issue(c_PT, 1'b0, 1'b1, c_CT);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      decrypt  = ~decrypt;
      key_cd   = {$urandom, $urandom_range(16777215, 0)};
      block_in = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
